ped_request_unit: RTL and testbench

PED_REQUEST_UNIT -- requirements
Module: ped_request_unit

---
 rtl/ped_request_unit.sv | 160 ++++++++++++++++
 tb/tb_ped_request_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_request_unit.sv
`default_nettype none
// ============================================================================
// Module   : ped_request_unit
// Brief    : Pedestrian pushbutton front end. Synchronizes and debounces the
//            raw button, turns accepted presses into a crossing request for
//            the light controller, and ignores presses until the crossing
//            has been served and a re-arm hold-off has elapsed.
// Revision : 1.0 - initial release
// ============================================================================
module ped_request_unit #(
    parameter int DEBOUNCE_CYC = 240000,
    parameter int REARM_SEC    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       sec_tick,
    input  logic       ped_green,
    output logic       req,
    output logic       wait_led,
    output logic       btn_stable,
    output logic [7:0] req_cnt
);

    // Counter widths; both are kept at least one bit wide.
    localparam int c_db_w    = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam int c_rearm_w = (REARM_SEC > 0) ? $clog2(REARM_SEC + 1) : 1;

    localparam logic [c_db_w-1:0]    c_db_max     = c_db_w'(DEBOUNCE_CYC);
    localparam logic [c_rearm_w-1:0] c_rearm_load = c_rearm_w'(REARM_SEC);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_req    = 2'd1;
    localparam logic [1:0] c_st_served = 2'd2;
    localparam logic [1:0] c_st_rearm  = 2'd3;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [c_db_w-1:0]    r_db_cnt;
    logic                 r_btn_stable;
    logic                 r_btn_stable_d;
    logic [1:0]           r_state;
    logic [c_rearm_w-1:0] r_rearm_cnt;
    logic                 r_req;
    logic                 r_wait_led;
    logic [7:0]           r_req_cnt;

    logic                 w_press;
    logic [1:0]           w_state_nxt;
    logic [c_rearm_w-1:0] w_rearm_nxt;
    logic                 w_accept;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept a new level only after it has differed from the
    // stable level for DEBOUNCE_CYC+1 consecutive edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt       <= '0;
            r_btn_stable   <= 1'b0;
            r_btn_stable_d <= 1'b0;
        end else begin
            r_btn_stable_d <= r_btn_stable;
            if (r_sync2 != r_btn_stable) begin
                if (r_db_cnt == c_db_max) begin
                    r_btn_stable <= ~r_btn_stable;
                    r_db_cnt     <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_db_w'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Only the rising edge of the debounced level is a press; release is ignored.
    assign w_press = r_btn_stable & ~r_btn_stable_d;

    // Request FSM next-state and re-arm counter next-value.
    always_comb begin
        w_state_nxt = r_state;
        w_rearm_nxt = r_rearm_cnt;
        w_accept    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_press && !ped_green) begin
                    w_state_nxt = c_st_req;
                    w_accept    = 1'b1;
                end
            end
            c_st_req: begin
                if (ped_green) begin
                    w_state_nxt = c_st_served;
                end
            end
            c_st_served: begin
                if (!ped_green) begin
                    if (REARM_SEC == 0) begin
                        w_state_nxt = c_st_idle;
                        w_rearm_nxt = '0;
                    end else begin
                        w_state_nxt = c_st_rearm;
                        w_rearm_nxt = c_rearm_load;
                    end
                end
            end
            c_st_rearm: begin
                if (sec_tick) begin
                    // A zero count cannot normally occur here; treat it as expired.
                    if ((r_rearm_cnt == c_rearm_w'(1)) || (r_rearm_cnt == '0)) begin
                        w_state_nxt = c_st_idle;
                        w_rearm_nxt = '0;
                    end else begin
                        w_rearm_nxt = r_rearm_cnt - c_rearm_w'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_rearm_nxt = '0;
            end
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_rearm_cnt <= '0;
            r_req       <= 1'b0;
            r_wait_led  <= 1'b0;
            r_req_cnt   <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_rearm_cnt <= w_rearm_nxt;
            r_req       <= (w_state_nxt == c_st_req);
            r_wait_led  <= (w_state_nxt == c_st_req);
            if (w_accept && (r_req_cnt != 8'hFF)) begin
                r_req_cnt <= r_req_cnt + 8'd1;
            end
        end
    end

    assign req        = r_req;
    assign wait_led   = r_wait_led;
    assign btn_stable = r_btn_stable;
    assign req_cnt    = r_req_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ped_request_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ped_request_unit
// Brief    : Self-checking bench for ped_request_unit with a behavioural
//            reference model, directed scenarios and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ped_request_unit;

    localparam int c_db = 4;
    localparam int c_rs = 2;

    localparam int c_ph_idle    = 0;
    localparam int c_ph_waiting = 1;
    localparam int c_ph_cross   = 2;
    localparam int c_ph_holdoff = 3;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       btn_raw   = 1'b0;
    logic       sec_tick  = 1'b0;
    logic       ped_green = 1'b0;
    logic       req;
    logic       wait_led;
    logic       btn_stable;
    logic [7:0] req_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ped_request_unit #(
        .DEBOUNCE_CYC (c_db),
        .REARM_SEC    (c_rs)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .sec_tick   (sec_tick),
        .ped_green  (ped_green),
        .req        (req),
        .wait_led   (wait_led),
        .btn_stable (btn_stable),
        .req_cnt    (req_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: button level accepted once the last DB+1 synchronized
    // samples all disagree with it; crossing phases follow the request rules.
    bit m_s1, m_s2, m_stable, m_stable_d;
    bit win[$];
    int m_phase     = c_ph_idle;
    int m_secs_left = 0;
    int m_count     = 0;

    always @(posedge clk) begin : p_model
        bit press;
        bit all_diff;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_stable_d = 0;
            win.delete();
            m_phase = c_ph_idle; m_secs_left = 0; m_count = 0;
        end else begin
            press = m_stable && !m_stable_d;
            case (m_phase)
                c_ph_idle:    if (press && !ped_green) begin
                                  m_phase = c_ph_waiting;
                                  if (m_count < 255) m_count++;
                              end
                c_ph_waiting: if (ped_green) m_phase = c_ph_cross;
                c_ph_cross:   if (!ped_green) begin
                                  if (c_rs == 0) m_phase = c_ph_idle;
                                  else begin m_phase = c_ph_holdoff; m_secs_left = c_rs; end
                              end
                default:      if (sec_tick) begin
                                  m_secs_left--;
                                  if (m_secs_left <= 0) m_phase = c_ph_idle;
                              end
            endcase
            m_stable_d = m_stable;
            win.push_back(m_s2);
            if (win.size() > c_db + 1) void'(win.pop_front());
            if (win.size() == c_db + 1) begin
                all_diff = 1;
                foreach (win[i]) if (win[i] == m_stable) all_diff = 0;
                if (all_diff) m_stable = !m_stable;
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("m_req",    {31'd0, req},        {31'd0, (m_phase == c_ph_waiting)});
        check("m_wait",   {31'd0, wait_led},   {31'd0, (m_phase == c_ph_waiting)});
        check("m_stable", {31'd0, btn_stable}, {31'd0, m_stable});
        check("m_cnt",    {24'd0, req_cnt},    m_count);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step(1);
        sec_tick = 1'b0;
        step(1);
    endtask

    task automatic serve_and_rearm();
        btn_raw   = 1'b0;
        ped_green = 1'b1;
        step(1);
        ped_green = 1'b0;
        step(1);
        tick();
        tick();
        step(7);
    endtask

    initial begin : p_stim
        int hold;
        rst = 1'b1;
        step(3);
        check("rst_req",    {31'd0, req},        0);
        check("rst_wait",   {31'd0, wait_led},   0);
        check("rst_stable", {31'd0, btn_stable}, 0);
        check("rst_cnt",    {24'd0, req_cnt},    0);
        rst = 1'b0;
        step(2);

        // Clean press: stable DB+2 edges after first sample, req one edge later.
        btn_raw = 1'b1;
        step(c_db + 2);
        check("cp_stable_early", {31'd0, btn_stable}, 0);
        step(1);
        check("cp_stable",    {31'd0, btn_stable}, 1);
        check("cp_req_early", {31'd0, req},        0);
        step(1);
        check("cp_req",  {31'd0, req},      1);
        check("cp_wait", {31'd0, wait_led}, 1);
        check("cp_cnt",  {24'd0, req_cnt},  1);

        // Handshake and re-arm hold-off.
        btn_raw   = 1'b0;
        ped_green = 1'b1;
        step(1);
        check("hs_req_drop", {31'd0, req}, 0);
        step(2);
        ped_green = 1'b0;
        step(1);
        step(5);
        btn_raw = 1'b1;
        step(1);
        tick();
        step(6);
        check("hs_ignored_req", {31'd0, req},     0);
        check("hs_ignored_cnt", {24'd0, req_cnt}, 1);
        btn_raw = 1'b0;
        step(8);
        tick();
        btn_raw = 1'b1;
        step(8);
        check("hs_rearmed_req", {31'd0, req},     1);
        check("hs_rearmed_cnt", {24'd0, req_cnt}, 2);
        serve_and_rearm();

        // Bounce: two-cycle pulses never survive the debounce window.
        for (int i = 0; i < 5; i++) begin
            btn_raw = 1'b1;
            step(2);
            btn_raw = 1'b0;
            step(2);
        end
        step(10);
        check("bn_stable", {31'd0, btn_stable}, 0);
        check("bn_req",    {31'd0, req},        0);

        // Press while the crossing is already green is ignored.
        ped_green = 1'b1;
        btn_raw   = 1'b1;
        step(10);
        check("pg_req", {31'd0, req},     0);
        check("pg_cnt", {24'd0, req_cnt}, 2);
        btn_raw = 1'b0;
        step(8);
        ped_green = 1'b0;
        step(1);

        // Reset in the middle of a pending request, button kept held.
        btn_raw = 1'b1;
        step(8);
        check("rq_req_before", {31'd0, req}, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rq_req",  {31'd0, req},      0);
        check("rq_wait", {31'd0, wait_led}, 0);
        check("rq_cnt",  {24'd0, req_cnt},  0);
        step(c_db + 2);
        check("rq_stable_early", {31'd0, btn_stable}, 0);
        step(1);
        check("rq_stable", {31'd0, btn_stable}, 1);
        step(1);
        check("rq_rereq", {31'd0, req}, 1);
        serve_and_rearm();

        // Saturation of the accepted-request counter.
        for (int i = 0; i < 260; i++) begin
            btn_raw = 1'b1;
            step(8);
            serve_and_rearm();
        end
        check("sat_cnt", {24'd0, req_cnt}, 255);

        // Random stimulus checked by the model.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                btn_raw = 1'($urandom_range(0, 1));
                hold    = int'($urandom_range(1, 12));
            end else begin
                hold--;
            end
            if ($urandom_range(0, 7) == 0) ped_green = ~ped_green;
            sec_tick = ($urandom_range(0, 5) == 0);
            rst      = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst      = 1'b0;
        sec_tick = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
